// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the RISC-V multicycle main controller:
// FSM state encoding, opcode/funct3 constants, ALU control codes,
// ALU-B select codes and the ALU operation class used by the decoder.
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    I_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    TRAP      = 4'd10
  } state_t;

  // ALU operation class handed to alu_control_decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_alu_control_decoder.sv
// ALU control decoder: maps the controller's ALU operation class plus
// funct3/funct7b5 to the 4-bit ALU control code.
//   alu_op      in  operation class (ADD, SUB, or decode from funct fields)
//   funct3      in  inst[14:12]
//   funct7b5    in  inst[30]
//   alu_control out ALU control code
//   illegal     out funct combination not supported (FUNCT class only)
module alu_control_decoder
  import multicycle_control_unit_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case ({funct3, funct7b5})
          {F3_ADD, 1'b0}: alu_control = ALU_ADD;
          {F3_ADD, 1'b1}: alu_control = ALU_SUB;
          {F3_AND, 1'b0}: alu_control = ALU_AND;
          {F3_OR,  1'b0}: alu_control = ALU_OR;
          default:        illegal     = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style main controller for the RISC-V multicycle datapath
// (lw, sw, add, sub, and, or, addi, beq). Traps on unsupported encodings
// and counts retired instructions.
//   clk, reset   clock, synchronous active-high reset
//   inst         current IR contents
//   zero         ALU zero flag
//   pc_write .. reg_write   datapath enables and selects
//   alu_control  4-bit ALU operation
//   halted       high while in TRAP
//   instret      retired-instruction count (wraps)
//   state_dbg    current state encoding
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst,
  input  logic             zero,
  output logic             pc_write,
  output logic             ior_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_control,
  output logic             reg_write,
  output logic             halted,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_dbg
);

  state_t     state, state_next;
  alu_op_t    alu_op;
  logic       r_illegal;
  logic       retire;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       unused_inst;

  assign opcode      = inst[6:0];
  assign funct3      = inst[14:12];
  assign funct7b5    = inst[30];
  assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

  // ALU class depends on state only, keeping the decoder out of the
  // main output block's combinational loop.
  assign alu_op = (state == R_EXEC) ? ALUOP_FUNCT :
                  (state == BRANCH) ? ALUOP_SUB   : ALUOP_ADD;

  alu_control_decoder u_alu_dec (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_control(alu_control),
    .illegal    (r_illegal)
  );

  always_comb begin
    pc_write   = 1'b0;
    ior_d      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    pc_source  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    reg_write  = 1'b0;
    retire     = 1'b0;
    state_next = state;
    case (state)
      FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM;
        if      (opcode == OP_LOAD   && funct3 == F3_WORD) state_next = MEM_ADDR;
        else if (opcode == OP_STORE  && funct3 == F3_WORD) state_next = MEM_ADDR;
        else if (opcode == OP_RTYPE)                       state_next = R_EXEC;
        else if (opcode == OP_IMM    && funct3 == F3_ADD)  state_next = I_EXEC;
        else if (opcode == OP_BRANCH && funct3 == F3_BEQ)  state_next = BRANCH;
        else                                               state_next = TRAP;
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read   = 1'b1;
        ior_d      = 1'b1;
        state_next = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEM_WRITE: begin
        mem_write  = 1'b1;
        ior_d      = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      R_EXEC: begin
        alu_src_a  = 1'b1;
        state_next = r_illegal ? TRAP : R_WB;
      end
      I_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        pc_source  = 1'b1;
        pc_write   = zero;
        retire     = 1'b1;
        state_next = FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = TRAP;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + 1'b1;
    end
  end

  assign halted    = (state == TRAP);
  assign state_dbg = state;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style main controller for the 32-bit RISC-V multicycle datapath: PC, shared instruction/data memory, IR, MDR, register file, A/B/ALUOut latches, four 2:1 muxes and the 3:1 ALU-B mux.
- Sequences fetch/decode/execute/memory/writeback for lw, sw, add, sub, and, or, addi and beq.
- Generates every datapath select and enable, including the ALU 4-bit control.
- Traps on unsupported encodings and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- inst  input  32  current IR contents
- zero  input  1  ALU zero flag (combinational)
- pc_write  output  1  PC load enable; already includes the branch condition
- ior_d  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read enable
- mem_write  output  1  memory write enable
- ir_write  output  1  IR load enable
- mem_to_reg  output  1  register write data select: 0=ALUOut, 1=MDR
- pc_source  output  1  next-PC select: 0=ALU result, 1=ALUOut
- alu_src_a  output  1  ALU A select: 0=PC, 1=A
- alu_src_b  output  2  ALU B select: 00=B, 01=const 4, 10=imm
- alu_control  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- reg_write  output  1  register file write enable
- halted  output  1  high while in TRAP
- instret  output  CNT_W  retired-instruction count
- state_dbg  output  4  current state encoding

Behaviour:
- Reset: clk, reset, synchronous active-high.
  - At the reset edge: state<=FETCH, instret<=0.
  - While reset is high, all enables are forced 0 (pc_write, mem_read, mem_write, ir_write, reg_write).
  - Reset asserted mid-instruction aborts it; there is no partial writeback after the edge.
- Decode fields: opcode inst[6:0], funct3 inst[14:12], funct7b5 inst[30].
- Default outputs in every state: all enables 0, selects 0, alu_control=0010.
- FETCH:
  - Memory path: mem_read=1, ior_d=0, ir_write=1.
  - PC+4 path: alu_src_a=0, alu_src_b=01, ADD, pc_source=0, pc_write=1.
  - Next state: DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=10, ADD. This forms the branch target (PC+4+imm) into ALUOut.
  - Next state by opcode and funct3:
    - 0000011 & funct3=010 -> MEM_ADDR
    - 0100011 & funct3=010 -> MEM_ADDR
    - 0110011 -> R_EXEC
    - 0010011 & funct3=000 -> I_EXEC
    - 1100011 & funct3=000 -> BRANCH
    - anything else -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next: MEM_READ if lw, MEM_WRITE if sw.
- MEM_READ: mem_read=1, ior_d=1. Next: MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, instret++. Next: FETCH.
- MEM_WRITE: mem_write=1, ior_d=1, instret++. Next: FETCH.
- R_EXEC:
  - alu_src_a=1, alu_src_b=00.
  - ALU operation from funct3/funct7b5:
    - 000/0 -> ADD
    - 000/1 -> SUB
    - 111/0 -> AND
    - 110/0 -> OR
  - Any other combination -> TRAP, with no writeback.
  - Next: R_WB.
- I_EXEC: alu_src_a=1, alu_src_b=10, ADD. Next: R_WB.
- R_WB: reg_write=1, mem_to_reg=0, instret++. Next: FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, SUB, pc_source=1.
  - pc_write=zero.
  - instret++. Next: FETCH.
- TRAP: halted=1, all enables 0, state held until reset.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3.
- instret wraps modulo 2^CNT_W.
- inst is sampled only in DECODE, R_EXEC and MEM_ADDR. IR is stable after FETCH.

Decomposition:
- Shared package holds:
  - the state enum (4 bits: FETCH=0 ... TRAP=10),
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_IMM, OP_BRANCH),
  - ALU control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB),
  - ALU-B select codes.
- One sub-module, alu_control_decoder: combinational {alu_op class, funct3, funct7b5} -> {alu_control, illegal}.

Test Plan:
- Reset held for 2 cycles, then released -> state_dbg=FETCH, instret=0, all enables 0 while reset is high; the first FETCH asserts ir_write and pc_write.
- Full datapath running the addi, lw, add, sub sequence (data[140]=82) -> x3=20, x8=82, x10=102, x11=20; instret=4 after 17 cycles.
- beq x3,x11,8 at PC 16 with x3==x11 -> BRANCH state asserts pc_write with pc_source=1; next fetch PC=28. After and/or: x13=16, x14=86.
- sw x3,150(x0) -> one MEM_WRITE cycle with mem_write=1 and ior_d=1; memory bytes 150..153 = 20,0,0,0; reg_write stays 0.
- inst=0xFFFFFFFF in DECODE -> TRAP next cycle, halted=1, no writes for 20 cycles; reset returns the block to FETCH.
- Reset asserted during MEM_READ of lw -> no reg_write occurs, state=FETCH after the edge, instret unchanged-then-cleared to 0.
